// File: rtl/if_bus_ctrl.sv
// Instruction-fetch bus controller: turns PC-stage fetch requests into single
// Wishbone classic read cycles, stalls the pipeline while a fetch is in flight,
// holds the fetched word across pipeline stalls, drops responses made stale by
// a flush, and aborts with a one-cycle error pulse if the slave never acks.
module if_bus_ctrl #(
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  output logic [31:0] cpu_inst_o,
  output logic        stallreq_o,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY       = 2'd1,
    WAIT_STALL = 2'd2,
    DRAIN      = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic              cyc_q, cyc_nxt;
  logic [31:0]       adr_q, adr_nxt;
  logic [31:0]       rd_buf, rd_buf_nxt;
  logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
  logic              bus_err_q, bus_err_nxt;
  logic              to_hit;

  // Last permitted wait cycle: without an ack here the cycle is abandoned.
  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // State and bus-side registers; reset drops the bus cycle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cyc_q     <= 1'b0;
      adr_q     <= '0;
      rd_buf    <= '0;
      to_cnt    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cyc_q     <= cyc_nxt;
      adr_q     <= adr_nxt;
      rd_buf    <= rd_buf_nxt;
      to_cnt    <= to_cnt_nxt;
      bus_err_q <= bus_err_nxt;
    end
  end

  // Next-state, next register values and the combinational CPU-side outputs.
  always_comb begin
    state_nxt   = state;
    cyc_nxt     = cyc_q;
    adr_nxt     = adr_q;
    rd_buf_nxt  = rd_buf;
    to_cnt_nxt  = to_cnt;
    bus_err_nxt = 1'b0;
    stallreq_o  = 1'b0;
    cpu_inst_o  = '0;
    case (state)
      IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          stallreq_o = 1'b1;
          adr_nxt    = cpu_addr_i;
          cyc_nxt    = 1'b1;
          to_cnt_nxt = '0;
          state_nxt  = BUSY;
        end
      end
      BUSY: begin
        stallreq_o = 1'b1;
        if (wb_ack_i && !flush_i) begin
          // Forward the word in the ack cycle so an unstalled pipe loses no cycle.
          cpu_inst_o = wb_dat_i;
          stallreq_o = 1'b0;
          cyc_nxt    = 1'b0;
          rd_buf_nxt = wb_dat_i;
          state_nxt  = (stall_i != '0) ? WAIT_STALL : IDLE;
        end else if (wb_ack_i) begin
          stallreq_o = 1'b0;
          cyc_nxt    = 1'b0;
          state_nxt  = IDLE;
        end else if (flush_i) begin
          // Bus cycle cannot be withdrawn on Wishbone classic; wait it out.
          state_nxt = DRAIN;
        end else if (to_hit) begin
          cyc_nxt     = 1'b0;
          bus_err_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
      end
      WAIT_STALL: begin
        // Keep presenting the fetched word until the pipeline moves on.
        cpu_inst_o = rd_buf;
        if (flush_i || (stall_i == '0)) begin
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        stallreq_o = 1'b1;
        if (wb_ack_i) begin
          cyc_nxt   = 1'b0;
          state_nxt = IDLE;
        end else if (to_hit) begin
          cyc_nxt     = 1'b0;
          bus_err_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cyc_nxt   = 1'b0;
      end
    endcase
  end

  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_adr_o  = adr_q;
  assign wb_we_o   = 1'b0;
  assign wb_sel_o  = 4'hF;
  assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_if_bus_ctrl.sv
// Bench for if_bus_ctrl: directed scenarios plus randomized fetches. Expected
// values come from a per-transaction timeline (request cycle, wait cycles, ack
// cycle, held-word cycles, idle cycle) derived from the fetch rules.
module tb_if_bus_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] inst;
  logic        stallreq;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat;
  logic        ack;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic        err;

  int checks   = 0;
  int failures = 0;

  if_bus_ctrl #(.TIMEOUT_CYC(TO), .TO_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall),
    .flush_i    (flush),
    .cpu_ce_i   (ce),
    .cpu_addr_i (addr),
    .cpu_inst_o (inst),
    .stallreq_o (stallreq),
    .wb_adr_o   (wb_adr),
    .wb_dat_i   (wb_dat),
    .wb_ack_i   (ack),
    .wb_cyc_o   (cyc),
    .wb_stb_o   (stb),
    .wb_we_o    (we),
    .wb_sel_o   (sel),
    .bus_err_o  (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Check the CPU-side and bus-strobe outputs at the falling edge.
  task automatic expect_cyc(input string tag, input logic e_stallreq, input logic [31:0] e_inst,
                            input logic e_cyc, input logic e_err);
    @(negedge clk);
    chk({tag, "_stallreq"}, {31'd0, stallreq}, {31'd0, e_stallreq});
    chk({tag, "_inst"}, inst, e_inst);
    chk({tag, "_cyc"}, {31'd0, cyc}, {31'd0, e_cyc});
    chk({tag, "_stb"}, {31'd0, stb}, {31'd0, e_cyc});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, e_err});
  endtask

  function automatic logic [5:0] nz_stall();
    return 6'($urandom_range(1, 63));
  endfunction

  // One complete fetch: w wait cycles before ack (w < TO), s held-word cycles.
  task automatic do_fetch(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input int w, input int s);
    ce = 1'b1; addr = a; flush = 1'b0; ack = 1'b0; stall = 6'($urandom); wb_dat = $urandom;
    expect_cyc({tag, "_req"}, 1'b1, 32'h0, 1'b0, 1'b0);
    next_cycle();
    for (int k = 0; k < w; k++) begin
      addr = $urandom; wb_dat = $urandom; ack = 1'b0; stall = 6'($urandom);
      expect_cyc({tag, "_wait"}, 1'b1, 32'h0, 1'b1, 1'b0);
      chk({tag, "_wait_adr"}, wb_adr, a);
      next_cycle();
    end
    ack = 1'b1; wb_dat = d; addr = $urandom;
    stall = (s > 0) ? nz_stall() : 6'd0;
    expect_cyc({tag, "_ack"}, 1'b0, d, 1'b1, 1'b0);
    chk({tag, "_ack_adr"}, wb_adr, a);
    chk({tag, "_we"}, {31'd0, we}, 32'd0);
    chk({tag, "_sel"}, {28'd0, sel}, 32'hF);
    next_cycle();
    for (int j = 0; j < s; j++) begin
      ce = 1'b0; ack = 1'($urandom); wb_dat = $urandom;
      stall = (j == s - 1) ? 6'd0 : nz_stall();
      expect_cyc({tag, "_hold"}, 1'b0, d, 1'b0, 1'b0);
      next_cycle();
    end
    ce = 1'b0; ack = 1'($urandom); stall = 6'($urandom); wb_dat = $urandom;
    expect_cyc({tag, "_idle"}, 1'b0, 32'h0, 1'b0, 1'b0);
    next_cycle();
  endtask

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; ce = 1'b0; addr = '0; wb_dat = '0; ack = 1'b0;
    #3;
    chk("rst_cyc", {31'd0, cyc}, 32'd0);
    chk("rst_stb", {31'd0, stb}, 32'd0);
    chk("rst_adr", wb_adr, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_stallreq", {31'd0, stallreq}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Zero-wait fetch, then wait states with a 4-cycle pipeline stall.
    do_fetch("t1", 32'h3000_0000, 32'hDEAD_BEEF, 0, 0);
    do_fetch("t2", 32'h3000_0004, 32'h3C01_1234, 3, 4);

    // Flush on the 2nd wait cycle: drain until ack, word dropped, new pc next.
    ce = 1'b1; addr = 32'h3000_0008; flush = 1'b0; ack = 1'b0; stall = '0;
    expect_cyc("t3_req", 1'b1, 32'h0, 1'b0, 1'b0);
    next_cycle();
    expect_cyc("t3_w0", 1'b1, 32'h0, 1'b1, 1'b0);
    next_cycle();
    flush = 1'b1; addr = 32'h0000_0100;
    expect_cyc("t3_flush", 1'b1, 32'h0, 1'b1, 1'b0);
    next_cycle();
    flush = 1'b0;
    expect_cyc("t3_drain", 1'b1, 32'h0, 1'b1, 1'b0);
    chk("t3_drain_adr", wb_adr, 32'h3000_0008);
    next_cycle();
    ack = 1'b1; wb_dat = 32'h1111_2222; stall = 6'b000011;
    expect_cyc("t3_drack", 1'b1, 32'h0, 1'b1, 1'b0);
    next_cycle();
    do_fetch("t3_new", 32'h0000_0100, 32'h2402_0005, 1, 0);

    // Flush coincident with ack: no held word even with stall active.
    ce = 1'b1; addr = 32'h3000_000C; flush = 1'b0; ack = 1'b0; stall = '0;
    expect_cyc("t4_req", 1'b1, 32'h0, 1'b0, 1'b0);
    next_cycle();
    ack = 1'b1; flush = 1'b1; wb_dat = 32'hAAAA_5555; stall = 6'b000111;
    expect_cyc("t4_ackfl", 1'b0, 32'h0, 1'b1, 1'b0);
    next_cycle();
    ack = 1'b0; flush = 1'b0; ce = 1'b0;
    expect_cyc("t4_after", 1'b0, 32'h0, 1'b0, 1'b0);
    next_cycle();

    // Timeout: slave silent for TO BUSY cycles.
    ce = 1'b1; addr = 32'h3000_0010; stall = '0; ack = 1'b0;
    expect_cyc("t5_req", 1'b1, 32'h0, 1'b0, 1'b0);
    next_cycle();
    for (int k = 0; k < TO; k++) begin
      expect_cyc("t5_busy", 1'b1, 32'h0, 1'b1, 1'b0);
      next_cycle();
    end
    ce = 1'b0;
    expect_cyc("t5_abort", 1'b0, 32'h0, 1'b0, 1'b1);
    next_cycle();
    expect_cyc("t5_errclr", 1'b0, 32'h0, 1'b0, 1'b0);
    next_cycle();
    do_fetch("t5_next", 32'h3000_0014, 32'h0000_0ACE, TO - 1, 1);

    // Timeout while draining a flushed fetch.
    ce = 1'b1; addr = 32'h3000_0018; ack = 1'b0;
    expect_cyc("t5d_req", 1'b1, 32'h0, 1'b0, 1'b0);
    next_cycle();
    flush = 1'b1;
    expect_cyc("t5d_flush", 1'b1, 32'h0, 1'b1, 1'b0);
    next_cycle();
    flush = 1'b0; ce = 1'b0;
    for (int k = 0; k < TO; k++) begin
      expect_cyc("t5d_drain", 1'b1, 32'h0, 1'b1, 1'b0);
      next_cycle();
    end
    expect_cyc("t5d_abort", 1'b0, 32'h0, 1'b0, 1'b1);
    next_cycle();

    // Flush while holding the word: it is not presented again.
    ce = 1'b1; addr = 32'h3000_001C; ack = 1'b0; stall = '0;
    expect_cyc("t7_req", 1'b1, 32'h0, 1'b0, 1'b0);
    next_cycle();
    ack = 1'b1; wb_dat = 32'h0BAD_F00D; stall = 6'b000001;
    expect_cyc("t7_ack", 1'b0, 32'h0BAD_F00D, 1'b1, 1'b0);
    next_cycle();
    ack = 1'b0; ce = 1'b0; flush = 1'b1;
    expect_cyc("t7_hold", 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0);
    next_cycle();
    flush = 1'b0;
    expect_cyc("t7_gone", 1'b0, 32'h0, 1'b0, 1'b0);
    next_cycle();

    // Flush in IDLE suppresses the request.
    ce = 1'b1; flush = 1'b1; stall = '0;
    expect_cyc("t8_idlefl", 1'b0, 32'h0, 1'b0, 1'b0);
    next_cycle();
    ce = 1'b0; flush = 1'b0;
    expect_cyc("t8_nobus", 1'b0, 32'h0, 1'b0, 1'b0);
    next_cycle();

    // Asynchronous reset in the middle of a bus cycle; late ack ignored.
    ce = 1'b1; addr = 32'h3000_0020; ack = 1'b0;
    expect_cyc("t6_req", 1'b1, 32'h0, 1'b0, 1'b0);
    next_cycle();
    #2 rst = 1'b1;
    #1;
    chk("t6_cyc", {31'd0, cyc}, 32'd0);
    chk("t6_stb", {31'd0, stb}, 32'd0);
    chk("t6_adr", wb_adr, 32'd0);
    chk("t6_err", {31'd0, err}, 32'd0);
    next_cycle();
    ce = 1'b0; ack = 1'b1; wb_dat = 32'h5A5A_5A5A;
    next_cycle();
    rst = 1'b0;
    expect_cyc("t6_lateack", 1'b0, 32'h0, 1'b0, 1'b0);
    next_cycle();
    ack = 1'b0;
    expect_cyc("t6_quiet", 1'b0, 32'h0, 1'b0, 1'b0);
    next_cycle();
    do_fetch("t6_first", 32'h3000_0024, 32'h2108_0001, 0, 2);

    // Randomized fetches over the full legal wait range.
    for (int n = 0; n < 40; n++) begin
      do_fetch("rnd", $urandom, $urandom, $urandom_range(0, TO - 1), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
